riscv_multicycle_controller: RTL and testbench

//  Moore FSM sequencing the multi-cycle RV32I datapath (PC/OldPC/IR/MDR/A/B/ALUOut regs, shared instr/data memory).

---
 rtl/riscv_multicycle_controller.sv | 260 ++++++++++++++++++++++++++
 tb/tb_riscv_multicycle_controller.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_multicycle_controller.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// riscv_multicycle_controller
//
// Moore controller for a multi-cycle RV32I datapath (PC/OldPC/IR/MDR/A/B/ALUOut
// registers, shared instruction/data memory). The state register is the only
// storage; every control output is decoded from the current state plus the IR
// fields and the ALU flags, so a control word always belongs to the state
// currently held.
//
// Supported: lw sw add sub and or xor slt sltu addi andi ori xori slti sltiu
//            beq bne blt bge jal jalr lui
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous, active-low reset (forces state RESET)
//   op         in   IR[6:0]
//   func3      in   IR[14:12]
//   func7      in   IR[30]
//   zero       in   ALU result == 0
//   neg        in   ALU result bit 31
//   PCWrite    out  load PC from Result
//   adrSrc     out  memory address: 0=PC 1=Result
//   memWrite   out  store B to mem[Adr]
//   IRWrite    out  load IR and OldPC
//   regWrite   out  write Result to rd
//   resultSrc  out  0=ALUOut 1=MDR 2=ALUResult 3=ImmExt
//   ALUSrcA    out  0=PC 1=OldPC 2=A 3=0
//   ALUSrcB    out  0=B 1=ImmExt 2=4 3=0
//   ALUControl out  000 ADD 001 SUB 010 AND 011 OR 100 XOR 101 SLT 110 SLTU
//   immSrc     out  000 I 001 S 010 B 011 J 100 U
//   illegal    out  unsupported-instruction flag
//
// Build option
//   ILLEGAL_TRAP_EN  defined: an unsupported op/func3 parks the FSM in HALT
//                    with illegal=1 until reset.
//                    undefined: the instruction retires as a NOP and illegal
//                    stays 0.
// -----------------------------------------------------------------------------
module riscv_multicycle_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] func3,
    input  logic       func7,
    input  logic       zero,
    input  logic       neg,
    output logic       PCWrite,
    output logic       adrSrc,
    output logic       memWrite,
    output logic       IRWrite,
    output logic       regWrite,
    output logic [1:0] resultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [2:0] immSrc,
    output logic       illegal
);

`ifdef ILLEGAL_TRAP_EN
    localparam logic TRAP_EN = 1'b1;
`else
    localparam logic TRAP_EN = 1'b0;
`endif

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    typedef enum logic [3:0] {
        S_RESET    = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADR   = 4'd3,
        S_MEMREAD  = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWRITE = 4'd6,
        S_EXECR    = 4'd7,
        S_EXECI    = 4'd8,
        S_ALUWB    = 4'd9,
        S_BRANCH   = 4'd10,
        S_JAL      = 4'd11,
        S_JALR1    = 4'd12,
        S_JALR2    = 4'd13,
        S_LUI      = 4'd14,
        S_HALT     = 4'd15
    } state_t;

    state_t state_q;
    state_t state_d;

    // func3 -> ALU opcode; sub_en lets func7 select SUB (R-type only).
    function automatic logic [2:0] alu_decode(input logic [2:0] f3, input logic sub_en);
        logic [2:0] ctl;
        case (f3)
            3'b000:  ctl = sub_en ? 3'b001 : 3'b000;
            3'b111:  ctl = 3'b010;
            3'b110:  ctl = 3'b011;
            3'b100:  ctl = 3'b100;
            3'b010:  ctl = 3'b101;
            3'b011:  ctl = 3'b110;
            default: ctl = 3'b000;
        endcase
        return ctl;
    endfunction

    // Branch condition from ALU flags of rs1-rs2; unsupported func3 never branches.
    function automatic logic branch_taken(input logic [2:0] f3, input logic z, input logic n);
        logic taken;
        case (f3)
            3'b000:  taken = z;
            3'b001:  taken = ~z;
            3'b100:  taken = n;
            3'b101:  taken = ~n;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

    // Next-state selection.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RESET:    state_d = S_FETCH;
            S_FETCH:    state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE:          state_d = S_EXECI;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR1;
                    OP_LUI:            state_d = S_LUI;
                    default:           state_d = TRAP_EN ? S_HALT : S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = S_FETCH;
            S_EXECR:    state_d = S_ALUWB;
            // Immediate shifts (func3 001/101) are not supported: skip the writeback.
            S_EXECI: begin
                if ((func3 == 3'b001) || (func3 == 3'b101)) begin
                    state_d = TRAP_EN ? S_HALT : S_FETCH;
                end else begin
                    state_d = S_ALUWB;
                end
            end
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            S_JALR1:    state_d = S_JALR2;
            S_JALR2:    state_d = S_ALUWB;
            S_LUI:      state_d = S_FETCH;
            S_HALT:     state_d = S_HALT;
            default:    state_d = S_RESET;
        endcase
    end

    // State register; reset aborts any instruction immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    // Per-state control word; anything not set stays 0.
    always_comb begin
        PCWrite    = 1'b0;
        adrSrc     = 1'b0;
        memWrite   = 1'b0;
        IRWrite    = 1'b0;
        regWrite   = 1'b0;
        resultSrc  = 2'd0;
        ALUSrcA    = 2'd0;
        ALUSrcB    = 2'd0;
        ALUControl = 3'b000;
        immSrc     = 3'b000;
        illegal    = 1'b0;
        case (state_q)
            S_FETCH: begin
                IRWrite   = 1'b1;
                PCWrite   = 1'b1;
                resultSrc = 2'd2;
                ALUSrcB   = 2'd2;
            end
            // Precompute OldPC+imm into ALUOut as a branch/jal target.
            S_DECODE: begin
                ALUSrcA = 2'd1;
                ALUSrcB = 2'd1;
                immSrc  = (op == OP_JAL) ? 3'b011 : 3'b010;
            end
            S_MEMADR: begin
                ALUSrcA = 2'd2;
                ALUSrcB = 2'd1;
                immSrc  = (op == OP_STORE) ? 3'b001 : 3'b000;
            end
            S_MEMREAD: begin
                adrSrc = 1'b1;
            end
            S_MEMWB: begin
                resultSrc = 2'd1;
                regWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                adrSrc   = 1'b1;
                memWrite = 1'b1;
            end
            S_EXECR: begin
                ALUSrcA    = 2'd2;
                ALUControl = alu_decode(func3, func7);
            end
            S_EXECI: begin
                ALUSrcA    = 2'd2;
                ALUSrcB    = 2'd1;
                ALUControl = alu_decode(func3, 1'b0);
            end
            S_ALUWB: begin
                regWrite = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA    = 2'd2;
                ALUControl = 3'b001;
                PCWrite    = branch_taken(func3, zero, neg);
            end
            // PC <= target held in ALUOut while ALU forms the link OldPC+4.
            S_JAL, S_JALR2: begin
                PCWrite = 1'b1;
                ALUSrcA = 2'd1;
                ALUSrcB = 2'd2;
            end
            S_JALR1: begin
                ALUSrcA = 2'd2;
                ALUSrcB = 2'd1;
            end
            S_LUI: begin
                immSrc    = 3'b100;
                resultSrc = 2'd3;
                regWrite  = 1'b1;
            end
            S_HALT: begin
                illegal = TRAP_EN;
            end
            default: begin
                illegal = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_riscv_multicycle_controller.sv
`timescale 1ns/1ps
// Directed bench for riscv_multicycle_controller. The control outputs are
// packed into one word {PCWrite adrSrc memWrite IRWrite regWrite resultSrc
// ALUSrcA ALUSrcB ALUControl immSrc illegal} and compared per cycle against
// hand-built per-state expected words, sampled on the falling edge.
module tb_riscv_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] op;
    logic [2:0] func3;
    logic       func7;
    logic       zero;
    logic       neg;
    logic       PCWrite, adrSrc, memWrite, IRWrite, regWrite, illegal;
    logic [1:0] resultSrc, ALUSrcA, ALUSrcB;
    logic [2:0] ALUControl, immSrc;
    logic [17:0] outs;

    int checks = 0;
    int failures = 0;

    riscv_multicycle_controller dut (
        .clk(clk), .rst(rst), .op(op), .func3(func3), .func7(func7),
        .zero(zero), .neg(neg), .PCWrite(PCWrite), .adrSrc(adrSrc),
        .memWrite(memWrite), .IRWrite(IRWrite), .regWrite(regWrite),
        .resultSrc(resultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUControl(ALUControl), .immSrc(immSrc), .illegal(illegal)
    );

    always #5 clk = ~clk;

    assign outs = {PCWrite, adrSrc, memWrite, IRWrite, regWrite, resultSrc,
                   ALUSrcA, ALUSrcB, ALUControl, immSrc, illegal};

    //                          pcw  adr  mw   irw  rw   res   A     B     alu    imm    ill
    localparam logic [17:0] E_ZERO   = 18'd0;
    localparam logic [17:0] E_FETCH  = {1'b1,1'b0,1'b0,1'b1,1'b0,2'd2,2'd0,2'd2,3'd0,3'd0,1'b0};
    localparam logic [17:0] E_DEC_B  = {5'b00000,2'd0,2'd1,2'd1,3'd0,3'd2,1'b0};
    localparam logic [17:0] E_DEC_J  = {5'b00000,2'd0,2'd1,2'd1,3'd0,3'd3,1'b0};
    localparam logic [17:0] E_MA_LW  = {5'b00000,2'd0,2'd2,2'd1,3'd0,3'd0,1'b0};
    localparam logic [17:0] E_MA_SW  = {5'b00000,2'd0,2'd2,2'd1,3'd0,3'd1,1'b0};
    localparam logic [17:0] E_MRD    = {5'b01000,2'd0,2'd0,2'd0,3'd0,3'd0,1'b0};
    localparam logic [17:0] E_MWB    = {5'b00001,2'd1,2'd0,2'd0,3'd0,3'd0,1'b0};
    localparam logic [17:0] E_MWR    = {5'b01100,2'd0,2'd0,2'd0,3'd0,3'd0,1'b0};
    localparam logic [17:0] E_EXR_SB = {5'b00000,2'd0,2'd2,2'd0,3'd1,3'd0,1'b0};
    localparam logic [17:0] E_EXR_XR = {5'b00000,2'd0,2'd2,2'd0,3'd4,3'd0,1'b0};
    localparam logic [17:0] E_EXI_AD = {5'b00000,2'd0,2'd2,2'd1,3'd0,3'd0,1'b0};
    localparam logic [17:0] E_EXI_SU = {5'b00000,2'd0,2'd2,2'd1,3'd6,3'd0,1'b0};
    localparam logic [17:0] E_ALUWB  = {5'b00001,2'd0,2'd0,2'd0,3'd0,3'd0,1'b0};
    localparam logic [17:0] E_BR_T   = {5'b10000,2'd0,2'd2,2'd0,3'd1,3'd0,1'b0};
    localparam logic [17:0] E_BR_N   = {5'b00000,2'd0,2'd2,2'd0,3'd1,3'd0,1'b0};
    localparam logic [17:0] E_JMP    = {5'b10000,2'd0,2'd1,2'd2,3'd0,3'd0,1'b0};
    localparam logic [17:0] E_JALR1  = {5'b00000,2'd0,2'd2,2'd1,3'd0,3'd0,1'b0};
    localparam logic [17:0] E_LUI    = {5'b00001,2'd3,2'd0,2'd0,3'd0,3'd4,1'b0};
    localparam logic [17:0] E_HALT   = {17'd0,1'b1};

    // Reset holds all outputs low; one RESET cycle after release, then FETCH.
    task automatic test_reset;
        rst = 1'b0; op = 7'd0; func3 = 3'd0; func7 = 1'b0; zero = 1'b0; neg = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (outs !== E_ZERO) begin failures++; $display("FAIL reset_hold got=%h exp=%h", outs, E_ZERO); end
        rst = 1'b1;
        #1;
        checks++;
        if (outs !== E_ZERO) begin failures++; $display("FAIL reset_release got=%h exp=%h", outs, E_ZERO); end
        @(negedge clk);
        checks++;
        if (outs !== E_FETCH) begin failures++; $display("FAIL reset_first_fetch got=%h exp=%h", outs, E_FETCH); end
    endtask

    // lw x5,8(x1): five cycles, regWrite only in MEMWB.
    task automatic test_lw;
        logic [17:0] exp [$];
        op = 7'b0000011; func3 = 3'b010; func7 = 1'b0;
        exp = '{E_FETCH, E_DEC_B, E_MA_LW, E_MRD, E_MWB, E_FETCH};
        foreach (exp[i]) begin
            if (i > 0) begin @(posedge clk); @(negedge clk); end
            checks++;
            if (outs !== exp[i]) begin failures++; $display("FAIL lw cyc%0d got=%h exp=%h", i, outs, exp[i]); end
        end
    endtask

    // sub x3,x1,x2: four cycles with SUB in EXECR.
    task automatic test_sub;
        logic [17:0] exp [$];
        op = 7'b0110011; func3 = 3'b000; func7 = 1'b1;
        exp = '{E_FETCH, E_DEC_B, E_EXR_SB, E_ALUWB, E_FETCH};
        foreach (exp[i]) begin
            if (i > 0) begin @(posedge clk); @(negedge clk); end
            checks++;
            if (outs !== exp[i]) begin failures++; $display("FAIL sub cyc%0d got=%h exp=%h", i, outs, exp[i]); end
        end
    endtask

    // xor (R), addi with func7 set (still ADD), sltiu.
    task automatic test_alu_ops;
        logic [6:0]  t_op [3]  = '{7'b0110011, 7'b0010011, 7'b0010011};
        logic [2:0]  t_f3 [3]  = '{3'b100, 3'b000, 3'b011};
        logic        t_f7 [3]  = '{1'b0, 1'b1, 1'b0};
        logic [17:0] t_ex [3]  = '{E_EXR_XR, E_EXI_AD, E_EXI_SU};
        logic [17:0] exp [$];
        for (int k = 0; k < 3; k++) begin
            op = t_op[k]; func3 = t_f3[k]; func7 = t_f7[k];
            exp = '{E_FETCH, E_DEC_B, t_ex[k], E_ALUWB, E_FETCH};
            foreach (exp[i]) begin
                if (i > 0) begin @(posedge clk); @(negedge clk); end
                checks++;
                if (outs !== exp[i]) begin failures++; $display("FAIL alu%0d cyc%0d got=%h exp=%h", k, i, outs, exp[i]); end
            end
        end
    endtask

    // beq taken/not taken, blt taken, bge not taken, bne taken.
    task automatic test_branch;
        logic [2:0]  t_f3 [5] = '{3'b000, 3'b000, 3'b100, 3'b101, 3'b001};
        logic        t_z  [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic        t_n  [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [17:0] t_ex [5] = '{E_BR_T, E_BR_N, E_BR_T, E_BR_N, E_BR_T};
        logic [17:0] exp [$];
        op = 7'b1100011; func7 = 1'b0;
        for (int k = 0; k < 5; k++) begin
            func3 = t_f3[k]; zero = t_z[k]; neg = t_n[k];
            exp = '{E_FETCH, E_DEC_B, t_ex[k], E_FETCH};
            foreach (exp[i]) begin
                if (i > 0) begin @(posedge clk); @(negedge clk); end
                checks++;
                if (outs !== exp[i]) begin failures++; $display("FAIL branch%0d cyc%0d got=%h exp=%h", k, i, outs, exp[i]); end
            end
        end
        zero = 1'b0; neg = 1'b0;
    endtask

    // jal (4 cycles), jalr x1,0(x1) (5 cycles), lui (3 cycles), back to back.
    task automatic test_jumps_lui;
        logic [17:0] exp [$];
        op = 7'b1101111; func3 = 3'b000; func7 = 1'b0;
        exp = '{E_FETCH, E_DEC_J, E_JMP, E_ALUWB, E_FETCH};
        foreach (exp[i]) begin
            if (i > 0) begin @(posedge clk); @(negedge clk); end
            checks++;
            if (outs !== exp[i]) begin failures++; $display("FAIL jal cyc%0d got=%h exp=%h", i, outs, exp[i]); end
        end
        op = 7'b1100111;
        exp = '{E_FETCH, E_DEC_B, E_JALR1, E_JMP, E_ALUWB, E_FETCH};
        foreach (exp[i]) begin
            if (i > 0) begin @(posedge clk); @(negedge clk); end
            checks++;
            if (outs !== exp[i]) begin failures++; $display("FAIL jalr cyc%0d got=%h exp=%h", i, outs, exp[i]); end
        end
        op = 7'b0110111;
        exp = '{E_FETCH, E_DEC_B, E_LUI, E_FETCH, E_DEC_B, E_LUI, E_FETCH};
        foreach (exp[i]) begin
            if (i > 0) begin @(posedge clk); @(negedge clk); end
            checks++;
            if (outs !== exp[i]) begin failures++; $display("FAIL lui cyc%0d got=%h exp=%h", i, outs, exp[i]); end
        end
    endtask

    // sw, then reset asserted mid-MEMWRITE kills memWrite immediately.
    task automatic test_sw_reset_abort;
        logic [17:0] exp [$];
        op = 7'b0100011; func3 = 3'b010; func7 = 1'b0;
        exp = '{E_FETCH, E_DEC_B, E_MA_SW, E_MWR};
        foreach (exp[i]) begin
            if (i > 0) begin @(posedge clk); @(negedge clk); end
            checks++;
            if (outs !== exp[i]) begin failures++; $display("FAIL sw cyc%0d got=%h exp=%h", i, outs, exp[i]); end
        end
        rst = 1'b0;
        #1;
        checks++;
        if (outs !== E_ZERO) begin failures++; $display("FAIL abort_same_cycle got=%h exp=%h", outs, E_ZERO); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (outs !== E_ZERO) begin failures++; $display("FAIL abort_reset_cycle got=%h exp=%h", outs, E_ZERO); end
        @(negedge clk);
        checks++;
        if (outs !== E_FETCH) begin failures++; $display("FAIL abort_refetch got=%h exp=%h", outs, E_FETCH); end
    endtask

    // Unsupported slli and op=0001111: HALT with the trap, NOP retire without.
    task automatic test_illegal;
        logic [17:0] exp [$];
        op = 7'b0010011; func3 = 3'b001; func7 = 1'b0;
`ifdef ILLEGAL_TRAP_EN
        exp = '{E_FETCH, E_DEC_B, E_EXI_AD, E_HALT, E_HALT, E_HALT};
`else
        exp = '{E_FETCH, E_DEC_B, E_EXI_AD, E_FETCH};
`endif
        foreach (exp[i]) begin
            if (i > 0) begin @(posedge clk); @(negedge clk); zero = ~zero; end
            checks++;
            if (outs !== exp[i]) begin failures++; $display("FAIL slli cyc%0d got=%h exp=%h", i, outs, exp[i]); end
        end
`ifdef ILLEGAL_TRAP_EN
        rst = 1'b0;
        #1;
        checks++;
        if (outs !== E_ZERO) begin failures++; $display("FAIL halt_reset got=%h exp=%h", outs, E_ZERO); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
`endif
        op = 7'b0001111; func3 = 3'b000;
`ifdef ILLEGAL_TRAP_EN
        exp = '{E_FETCH, E_DEC_B, E_HALT, E_HALT, E_HALT};
`else
        exp = '{E_FETCH, E_DEC_B, E_FETCH, E_DEC_B, E_FETCH};
`endif
        foreach (exp[i]) begin
            if (i > 0) begin @(posedge clk); @(negedge clk); end
            checks++;
            if (outs !== exp[i]) begin failures++; $display("FAIL fence cyc%0d got=%h exp=%h", i, outs, exp[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sub();
        test_alu_ops();
        test_branch();
        test_jumps_lui();
        test_sw_reset_abort();
        test_illegal();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
